memory_board: RTL and testbench
===============================

MEMORY_BOARD -- requirements
Module: memory_board

Interface
REQ-001 Parameter ROWS, default 4, board rows; ROWS*COLS SHALL be even and at least 2.
REQ-002 Parameter COLS, default 4, board columns.
REQ-003 Parameter SYM_W, default 3, symbol width in bits.
REQ-004 Parameter SHOW_CYCLES, default 25_000_000, mismatch display time in clocks; minimum 1.
REQ-005 Derived widths: RW=max(1,clog2(ROWS)), CW=max(1,clog2(COLS)), PW=clog2(ROWS*COLS/2+1); N=ROWS*COLS.
REQ-006 clk  in  1  single clock; all state changes on rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 load_en  in  1  write load_sym into cell (load_row,load_col).
REQ-009 load_row  in  RW / load_col  in  CW / load_sym  in  SYM_W  load address and data.
REQ-010 sel_valid  in  1 / sel_row  in  RW / sel_col  in  CW  player card selection.
REQ-011 sel_ready  out  1  selection accepted this cycle when sel_valid&sel_ready.
REQ-012 rd_row  in  RW / rd_col  in  CW  combinational read address.
REQ-013 rd_sym  out  SYM_W / rd_state  out  2  symbol and status of read cell; status 00 hidden, 01 revealed, 10 matched.
REQ-014 match_pulse  out  1 / mismatch_pulse  out  1  one-cycle pair result strobes.
REQ-015 turn  out  1  active player (0/1).
REQ-016 score0, score1  out  PW each  pairs found per player; pairs_found  out  PW  total.
REQ-017 game_over  out  1  all pairs matched.

Function
REQ-018 FSM states: IDLE, FIRST, CHECK, SHOW, DONE.
REQ-019 sel_ready SHALL be 1 only in IDLE or FIRST with load_en=0.
REQ-020 Accepted selection SHALL be ignored (no state change) if address out of range or cell not hidden.
REQ-021 IDLE: valid accepted hidden cell -> cell revealed, address stored as first, go FIRST.
REQ-022 FIRST: valid accepted hidden cell -> revealed, stored as second, go CHECK.
REQ-023 CHECK (one cycle): match_pulse or mismatch_pulse high for exactly this cycle, from symbol equality.
REQ-024 Match: both cells -> matched, score of turn +1, pairs_found +1, turn unchanged; next DONE if pairs_found reaches N/2, else IDLE.
REQ-025 Mismatch: timer loaded SHOW_CYCLES-1, go SHOW; both cells stay revealed.
REQ-026 SHOW: timer decrements each cycle; at 0 both cells -> hidden, turn toggles, go IDLE; revealed for exactly SHOW_CYCLES cycles after CHECK.
REQ-027 DONE: game_over=1, sel_ready=0; held until reset.
REQ-028 load_en honoured only in IDLE; ignored elsewhere; out-of-range load ignored; load does not alter cell status.
REQ-029 rd_sym SHALL be 0 when read cell hidden or out of range, else stored symbol; rd_state 00 when out of range.
REQ-030 Score and pair counters SHALL not exceed N/2; no wrap.

Reset
REQ-031 reset low SHALL immediately: state IDLE, all cells hidden, turn 0, scores and pairs_found 0, strobes 0, game_over 0, timer 0.
REQ-032 reset low SHALL load cell i=row*COLS+col with symbol (i/2) mod 2^SYM_W.
REQ-033 Reset asserted in any state, including mid-SHOW, SHALL abort the game with no residual reveal.

Verification (4x4, SYM_W=3, SHOW_CYCLES=4)
REQ-034 Reset release -> every rd_state 00, rd_sym 0, pairs_found 0, turn 0, sel_ready 1.
REQ-035 Select (0,0) then (0,1) -> match_pulse one cycle after second accept, both rd_state 10, rd_sym 0, score0=1, turn 0.
REQ-036 Select (0,0) then (0,2) -> mismatch_pulse, rd_sym 0 and 1 shown 4 cycles, then rd_state 00, turn 1, sel_ready 0 throughout.
REQ-037 In FIRST reselect (0,0), then select matched cell -> both ignored, state FIRST; load (0,2)=0 in IDLE, then (0,0)/(0,2) matches.
REQ-038 Match all 8 pairs alternating players -> game_over 1, pairs_found 8, score0+score1=8, sel_ready 0.
REQ-039 Assert reset two cycles into SHOW -> all outputs return to reset values asynchronously, cells re-initialised.

Source files
------------

// File: rtl/memory_board_if.sv
// Signal bundle for the memory game board: card loading, player selection, read port and status.
interface memory_board_if #(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 4,
  parameter int unsigned SYM_W = 3
);
  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned PW = $clog2(N / 2 + 1);

  logic             load_en;
  logic [RW-1:0]    load_row;
  logic [CW-1:0]    load_col;
  logic [SYM_W-1:0] load_sym;
  logic             sel_valid;
  logic [RW-1:0]    sel_row;
  logic [CW-1:0]    sel_col;
  logic             sel_ready;
  logic [RW-1:0]    rd_row;
  logic [CW-1:0]    rd_col;
  logic [SYM_W-1:0] rd_sym;
  logic [1:0]       rd_state;
  logic             match_pulse;
  logic             mismatch_pulse;
  logic             turn;
  logic [PW-1:0]    score0;
  logic [PW-1:0]    score1;
  logic [PW-1:0]    pairs_found;
  logic             game_over;

  modport master (
    output load_en, load_row, load_col, load_sym,
    output sel_valid, sel_row, sel_col,
    output rd_row, rd_col,
    input  sel_ready, rd_sym, rd_state, match_pulse, mismatch_pulse,
    input  turn, score0, score1, pairs_found, game_over
  );

  modport slave (
    input  load_en, load_row, load_col, load_sym,
    input  sel_valid, sel_row, sel_col,
    input  rd_row, rd_col,
    output sel_ready, rd_sym, rd_state, match_pulse, mismatch_pulse,
    output turn, score0, score1, pairs_found, game_over
  );
endinterface

// File: rtl/memory_board.sv
// Two-player memory (pairs) game: card storage, selection handshake, pair check,
// timed mismatch display and per-player scoring.
module memory_board #(
  parameter int unsigned ROWS        = 4,
  parameter int unsigned COLS        = 4,
  parameter int unsigned SYM_W       = 3,
  parameter int unsigned SHOW_CYCLES = 25_000_000
) (
  input logic           clk,
  input logic           reset,
  memory_board_if.slave bus
);
  localparam int unsigned N    = ROWS * COLS;
  localparam int unsigned HALF = N / 2;
  localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned PW   = $clog2(HALF + 1);
  localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned TW   = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  localparam logic [1:0] CellHidden   = 2'b00;
  localparam logic [1:0] CellRevealed = 2'b01;
  localparam logic [1:0] CellMatched  = 2'b10;

  typedef enum logic [2:0] {StIdle, StFirst, StCheck, StShow, StDone} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    first_q, first_d;
  logic [IW-1:0]    second_q, second_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             turn_q, turn_d;
  logic [PW-1:0]    score0_q, score0_d;
  logic [PW-1:0]    score1_q, score1_d;
  logic [PW-1:0]    pairs_q, pairs_d;
  logic [SYM_W-1:0] sym_q [N];
  logic [SYM_W-1:0] sym_d [N];
  logic [1:0]       cell_st_q [N];
  logic [1:0]       cell_st_d [N];

  function automatic logic in_range(input logic [RW-1:0] row, input logic [CW-1:0] col);
    return (32'(row) < ROWS) && (32'(col) < COLS);
  endfunction

  function automatic logic [IW-1:0] cell_idx(input logic [RW-1:0] row, input logic [CW-1:0] col);
    return IW'(32'(row) * COLS + 32'(col));
  endfunction

  logic          sel_ready, sel_ok, load_ok, is_match, rd_ok;
  logic [IW-1:0] sel_idx, load_idx, rd_idx;

  assign sel_ready = ((state_q == StIdle) || (state_q == StFirst)) && !bus.load_en;
  assign sel_idx   = cell_idx(bus.sel_row, bus.sel_col);
  assign sel_ok    = bus.sel_valid && sel_ready && in_range(bus.sel_row, bus.sel_col) &&
                     (cell_st_q[sel_idx] == CellHidden);
  assign load_idx  = cell_idx(bus.load_row, bus.load_col);
  assign load_ok   = bus.load_en && in_range(bus.load_row, bus.load_col);
  assign is_match  = (sym_q[first_q] == sym_q[second_q]);

  always_comb begin
    state_d   = state_q;
    first_d   = first_q;
    second_d  = second_q;
    timer_d   = timer_q;
    turn_d    = turn_q;
    score0_d  = score0_q;
    score1_d  = score1_q;
    pairs_d   = pairs_q;
    sym_d     = sym_q;
    cell_st_d = cell_st_q;

    unique case (state_q)
      StIdle: begin
        if (load_ok) begin
          sym_d[load_idx] = bus.load_sym;
        end else if (sel_ok) begin
          cell_st_d[sel_idx] = CellRevealed;
          first_d            = sel_idx;
          state_d            = StFirst;
        end
      end
      StFirst: begin
        if (sel_ok) begin
          cell_st_d[sel_idx] = CellRevealed;
          second_d           = sel_idx;
          state_d            = StCheck;
        end
      end
      StCheck: begin
        if (is_match) begin
          cell_st_d[first_q]  = CellMatched;
          cell_st_d[second_q] = CellMatched;
          // Counters saturate at the pair count rather than wrapping.
          if (!turn_q) begin
            if (score0_q < PW'(HALF)) score0_d = score0_q + PW'(1);
          end else begin
            if (score1_q < PW'(HALF)) score1_d = score1_q + PW'(1);
          end
          if (pairs_q < PW'(HALF)) pairs_d = pairs_q + PW'(1);
          state_d = (pairs_d == PW'(HALF)) ? StDone : StIdle;
        end else begin
          timer_d = TW'(SHOW_CYCLES - 1);
          state_d = StShow;
        end
      end
      StShow: begin
        if (timer_q == '0) begin
          cell_st_d[first_q]  = CellHidden;
          cell_st_d[second_q] = CellHidden;
          turn_d              = ~turn_q;
          state_d             = StIdle;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      StDone: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      first_q  <= '0;
      second_q <= '0;
      timer_q  <= '0;
      turn_q   <= 1'b0;
      score0_q <= '0;
      score1_q <= '0;
      pairs_q  <= '0;
      // Default deck: consecutive cells form pairs.
      for (int i = 0; i < N; i++) begin
        sym_q[i]     <= SYM_W'(i / 2);
        cell_st_q[i] <= CellHidden;
      end
    end else begin
      state_q   <= state_d;
      first_q   <= first_d;
      second_q  <= second_d;
      timer_q   <= timer_d;
      turn_q    <= turn_d;
      score0_q  <= score0_d;
      score1_q  <= score1_d;
      pairs_q   <= pairs_d;
      sym_q     <= sym_d;
      cell_st_q <= cell_st_d;
    end
  end

  assign rd_ok  = in_range(bus.rd_row, bus.rd_col);
  assign rd_idx = cell_idx(bus.rd_row, bus.rd_col);

  assign bus.sel_ready      = sel_ready;
  assign bus.rd_state       = rd_ok ? cell_st_q[rd_idx] : CellHidden;
  assign bus.rd_sym         = (rd_ok && (cell_st_q[rd_idx] != CellHidden)) ? sym_q[rd_idx] : '0;
  assign bus.match_pulse    = (state_q == StCheck) && is_match;
  assign bus.mismatch_pulse = (state_q == StCheck) && !is_match;
  assign bus.turn           = turn_q;
  assign bus.score0         = score0_q;
  assign bus.score1         = score1_q;
  assign bus.pairs_found    = pairs_q;
  assign bus.game_over      = (state_q == StDone);

endmodule

// File: tb/tb_memory_board.sv
// Self-checking bench for memory_board on a 4x4 board with a short mismatch display.
module tb_memory_board;
  localparam int unsigned ROWS        = 4;
  localparam int unsigned COLS        = 4;
  localparam int unsigned SYM_W       = 3;
  localparam int unsigned SHOW_CYCLES = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #10 clk = ~clk;

  memory_board_if #(.ROWS(ROWS), .COLS(COLS), .SYM_W(SYM_W)) bus ();

  memory_board #(
    .ROWS(ROWS), .COLS(COLS), .SYM_W(SYM_W), .SHOW_CYCLES(SHOW_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] r0, c0, r1, c1;
    logic       match;
    logic       turn;
    int         s0, s1, pairs;
  } pair_vec_t;

  pair_vec_t vecs [11];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int exp_sym(input int r, input int c);
    return ((r * COLS + c) / 2) % (1 << SYM_W);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic select(input logic [1:0] r, input logic [1:0] c);
    bus.sel_valid = 1'b1;
    bus.sel_row   = r;
    bus.sel_col   = c;
    step();
    bus.sel_valid = 1'b0;
  endtask

  task automatic load(input logic [1:0] r, input logic [1:0] c, input logic [2:0] s);
    bus.load_en  = 1'b1;
    bus.load_row = r;
    bus.load_col = c;
    bus.load_sym = s;
    #1;
    check("sel_ready during load", int'(bus.sel_ready), 0);
    step();
    bus.load_en = 1'b0;
  endtask

  task automatic check_cell(input string tag, input logic [1:0] r, input logic [1:0] c,
                            input int st, input int sym);
    bus.rd_row = r;
    bus.rd_col = c;
    #1;
    check({tag, " rd_state"}, int'(bus.rd_state), st);
    check({tag, " rd_sym"}, int'(bus.rd_sym), sym);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    bus.load_en   = 1'b0;
    bus.load_row  = '0;
    bus.load_col  = '0;
    bus.load_sym  = '0;
    bus.sel_valid = 1'b0;
    bus.sel_row   = '0;
    bus.sel_col   = '0;
    bus.rd_row    = '0;
    bus.rd_col    = '0;

    // Turn sequence: pairs, mismatches to alternate players, final pair ends the game.
    vecs[0]  = '{2'd0, 2'd0, 2'd0, 2'd1, 1'b1, 1'b0, 1, 0, 1};
    vecs[1]  = '{2'd0, 2'd2, 2'd1, 2'd0, 1'b0, 1'b1, 1, 0, 1};
    vecs[2]  = '{2'd0, 2'd2, 2'd0, 2'd3, 1'b1, 1'b1, 1, 1, 2};
    vecs[3]  = '{2'd1, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 1, 1, 2};
    vecs[4]  = '{2'd1, 2'd0, 2'd1, 2'd1, 1'b1, 1'b0, 2, 1, 3};
    vecs[5]  = '{2'd1, 2'd2, 2'd1, 2'd3, 1'b1, 1'b0, 3, 1, 4};
    vecs[6]  = '{2'd2, 2'd0, 2'd3, 2'd3, 1'b0, 1'b1, 3, 1, 4};
    vecs[7]  = '{2'd2, 2'd0, 2'd2, 2'd1, 1'b1, 1'b1, 3, 2, 5};
    vecs[8]  = '{2'd2, 2'd2, 2'd2, 2'd3, 1'b1, 1'b1, 3, 3, 6};
    vecs[9]  = '{2'd3, 2'd0, 2'd3, 2'd1, 1'b1, 1'b1, 3, 4, 7};
    vecs[10] = '{2'd3, 2'd3, 2'd3, 2'd2, 1'b1, 1'b1, 3, 5, 8};

    // Reset state
    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        check_cell($sformatf("reset cell(%0d,%0d)", r, c), 2'(r), 2'(c), 0, 0);
      end
    end
    check("reset pairs_found", int'(bus.pairs_found), 0);
    check("reset turn", int'(bus.turn), 0);
    check("reset sel_ready", int'(bus.sel_ready), 1);
    check("reset game_over", int'(bus.game_over), 0);
    check("reset score0", int'(bus.score0), 0);
    check("reset score1", int'(bus.score1), 0);
    check("reset match_pulse", int'(bus.match_pulse), 0);
    check("reset mismatch_pulse", int'(bus.mismatch_pulse), 0);

    // Mismatch display timing
    select(2'd0, 2'd0);
    select(2'd0, 2'd2);
    check("mm pulse", int'(bus.mismatch_pulse), 1);
    check("mm no match", int'(bus.match_pulse), 0);
    check("mm check sel_ready", int'(bus.sel_ready), 0);
    for (int k = 0; k < int'(SHOW_CYCLES); k++) begin
      step();
      check($sformatf("mm show%0d sel_ready", k), int'(bus.sel_ready), 0);
      check($sformatf("mm show%0d pulse", k), int'(bus.mismatch_pulse), 0);
      check_cell($sformatf("mm show%0d (0,0)", k), 2'd0, 2'd0, 1, 0);
      check_cell($sformatf("mm show%0d (0,2)", k), 2'd0, 2'd2, 1, 1);
    end
    step();
    check_cell("mm after (0,0)", 2'd0, 2'd0, 0, 0);
    check_cell("mm after (0,2)", 2'd0, 2'd2, 0, 0);
    check("mm after turn", int'(bus.turn), 1);
    check("mm after sel_ready", int'(bus.sel_ready), 1);

    // Ignored selections while holding a first card
    do_reset();
    select(2'd1, 2'd0);
    select(2'd1, 2'd1);
    check("ign setup match", int'(bus.match_pulse), 1);
    step();
    select(2'd0, 2'd0);
    select(2'd0, 2'd0);
    check("ign reselect sel_ready", int'(bus.sel_ready), 1);
    check("ign reselect match", int'(bus.match_pulse), 0);
    check("ign reselect mismatch", int'(bus.mismatch_pulse), 0);
    check_cell("ign reselect (0,0)", 2'd0, 2'd0, 1, 0);
    select(2'd1, 2'd0);
    check("ign matched sel_ready", int'(bus.sel_ready), 1);
    check("ign matched match", int'(bus.match_pulse), 0);
    check_cell("ign matched (1,0)", 2'd1, 2'd0, 2, 2);
    select(2'd0, 2'd1);
    check("ign final match", int'(bus.match_pulse), 1);
    step();
    check("ign pairs_found", int'(bus.pairs_found), 2);
    check("ign score0", int'(bus.score0), 2);

    // Loading: honoured in IDLE, ignored in FIRST, never changes status
    do_reset();
    load(2'd0, 2'd2, 3'd0);
    check_cell("load idle (0,2)", 2'd0, 2'd2, 0, 0);
    select(2'd0, 2'd0);
    load(2'd0, 2'd0, 3'd5);
    check_cell("load first (0,0)", 2'd0, 2'd0, 1, 0);
    select(2'd0, 2'd2);
    check("load match", int'(bus.match_pulse), 1);
    step();
    check_cell("load matched (0,0)", 2'd0, 2'd0, 2, 0);
    check_cell("load matched (0,2)", 2'd0, 2'd2, 2, 0);
    check("load score0", int'(bus.score0), 1);

    // Asynchronous reset in the middle of the mismatch display
    do_reset();
    load(2'd0, 2'd2, 3'd5);
    select(2'd0, 2'd0);
    select(2'd0, 2'd2);
    check("ar mismatch", int'(bus.mismatch_pulse), 1);
    step();
    step();
    check_cell("ar show (0,2)", 2'd0, 2'd2, 1, 5);
    reset = 1'b0;
    #1;
    check_cell("ar (0,0)", 2'd0, 2'd0, 0, 0);
    check_cell("ar (0,2)", 2'd0, 2'd2, 0, 0);
    check("ar turn", int'(bus.turn), 0);
    check("ar sel_ready", int'(bus.sel_ready), 1);
    check("ar pulse", int'(bus.mismatch_pulse), 0);
    step();
    reset = 1'b1;
    select(2'd0, 2'd2);
    select(2'd0, 2'd3);
    check("ar reinit match", int'(bus.match_pulse), 1);
    step();
    check_cell("ar reinit (0,2)", 2'd0, 2'd2, 2, 1);

    // Full game from the table
    do_reset();
    for (int i = 0; i < 11; i++) begin
      check($sformatf("v%0d sel_ready", i), int'(bus.sel_ready), 1);
      select(vecs[i].r0, vecs[i].c0);
      select(vecs[i].r1, vecs[i].c1);
      check($sformatf("v%0d match_pulse", i), int'(bus.match_pulse), int'(vecs[i].match));
      check($sformatf("v%0d mismatch_pulse", i), int'(bus.mismatch_pulse),
            int'(!vecs[i].match));
      step();
      if (vecs[i].match) begin
        check_cell($sformatf("v%0d first", i), vecs[i].r0, vecs[i].c0, 2,
                   exp_sym(int'(vecs[i].r0), int'(vecs[i].c0)));
        check_cell($sformatf("v%0d second", i), vecs[i].r1, vecs[i].c1, 2,
                   exp_sym(int'(vecs[i].r1), int'(vecs[i].c1)));
      end else begin
        check($sformatf("v%0d show sel_ready", i), int'(bus.sel_ready), 0);
        check_cell($sformatf("v%0d show", i), vecs[i].r0, vecs[i].c0, 1,
                   exp_sym(int'(vecs[i].r0), int'(vecs[i].c0)));
        repeat (SHOW_CYCLES) step();
        check_cell($sformatf("v%0d hidden first", i), vecs[i].r0, vecs[i].c0, 0, 0);
        check_cell($sformatf("v%0d hidden second", i), vecs[i].r1, vecs[i].c1, 0, 0);
      end
      check($sformatf("v%0d turn", i), int'(bus.turn), int'(vecs[i].turn));
      check($sformatf("v%0d score0", i), int'(bus.score0), vecs[i].s0);
      check($sformatf("v%0d score1", i), int'(bus.score1), vecs[i].s1);
      check($sformatf("v%0d pairs_found", i), int'(bus.pairs_found), vecs[i].pairs);
      check($sformatf("v%0d game_over", i), int'(bus.game_over), (i == 10) ? 1 : 0);
    end
    check("end sel_ready", int'(bus.sel_ready), 0);
    check("end score sum", int'(bus.score0) + int'(bus.score1), 8);
    select(2'd0, 2'd0);
    repeat (3) step();
    check("end game_over held", int'(bus.game_over), 1);
    check("end pairs held", int'(bus.pairs_found), 8);
    check("end no pulse", int'(bus.match_pulse) + int'(bus.mismatch_pulse), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
